// File: rtl/tlul_mem_responder_pkg.sv
// Types local to the memory responder: the queued response entry and
// the opcode legality check used at request accept.
package tlul_mem_responder_pkg;
  import tlul_pkg::*;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } rsp_entry_t;

  function automatic logic opcode_supported(input logic [2:0] op);
    return (op == PutFullData) || (op == PutPartialData) || (op == Get);
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL bus definitions shared by the responder and its users:
// A/D channel opcodes and the host-to-device / device-to-host structs.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [3:0]  d_user;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_mem_responder_if.sv
// TL-UL request/response bundle between a host and the memory responder.
interface tlul_mem_responder_if;
  tlul_pkg::tl_h2d_t tl_i;
  tlul_pkg::tl_d2h_t tl_o;

  modport master (output tl_i, input tl_o);
  modport slave  (input tl_i, output tl_o);
endinterface

// File: rtl/tlul_mem_rsp_fifo.sv
// In-order response queue; pointers carry an extra wrap bit so full and
// empty are told apart without a separate occupancy counter.
module tlul_mem_rsp_fifo
  import tlul_mem_responder_pkg::*;
#(
  parameter int RspDepth = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  output logic       full,
  input  logic       pop_ready,
  output logic       empty,
  input  rsp_entry_t push_data,
  output rsp_entry_t head_data
);

  localparam int IdxW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  logic [IdxW:0] wr_ptr, rd_ptr;
  logic          push, pop;
  rsp_entry_t    store [RspDepth];

  // Index wraps at RspDepth (not a power of two in general), toggling the wrap bit.
  function automatic logic [IdxW:0] bump(input logic [IdxW:0] p);
    if (p[IdxW-1:0] == IdxW'(RspDepth - 1))
      return {~p[IdxW], {IdxW{1'b0}}};
    else
      return {p[IdxW], p[IdxW-1:0] + IdxW'(1)};
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IdxW] != rd_ptr[IdxW]) &&
                 (wr_ptr[IdxW-1:0] == rd_ptr[IdxW-1:0]);
  assign push  = push_valid && !full;
  assign pop   = pop_ready && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr[IdxW-1:0]] <= push_data;
  end

  assign head_data = store[rd_ptr[IdxW-1:0]];

endmodule

// File: rtl/tlul_mem_responder.sv
// TL-UL device end backed by a small word memory: decodes and checks each
// A-channel request at accept, updates memory, and queues the D response.
module tlul_mem_responder
  import tlul_pkg::*;
  import tlul_mem_responder_pkg::*;
#(
  parameter int Depth    = 16,
  parameter int RspDepth = 2
) (
  input  logic           clk,
  input  logic           rst,
  tlul_mem_responder_if.slave tl
);

  localparam int          AW       = $clog2(Depth);
  localparam logic [31:0] MemBytes = 32'(Depth * 4);

  tl_h2d_t    req;
  tl_d2h_t    rsp;
  logic       fifo_full, fifo_empty;
  logic       a_ready, accept;
  logic       is_get, is_put, req_err, do_write;
  logic [AW-1:0] idx;
  rsp_entry_t push_entry, head_entry;
  logic [31:0] mem [Depth];

  assign req = tl.tl_i;

  // a_ready looks only at queue state so it never waits on a_valid or d_ready.
  assign a_ready  = !rst && !fifo_full;
  assign accept   = req.a_valid && a_ready;
  assign idx      = req.a_address[2 +: AW];
  assign is_get   = (req.a_opcode == Get);
  assign is_put   = (req.a_opcode == PutFullData) || (req.a_opcode == PutPartialData);
  assign req_err  = !opcode_supported(req.a_opcode) || (req.a_size > 2'd2) ||
                    (req.a_address >= MemBytes);
  assign do_write = accept && is_put && !req_err;

  always_comb begin
    push_entry        = '0;
    push_entry.opcode = is_get ? AccessAckData : AccessAck;
    push_entry.size   = req.a_size;
    push_entry.source = req.a_source;
    push_entry.error  = req_err;
    if (is_get && !req_err) push_entry.data = mem[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < 4; b++)
        if (req.a_mask[b]) mem[idx][8*b +: 8] <= req.a_data[8*b +: 8];
    end
  end

  tlul_mem_rsp_fifo #(.RspDepth(RspDepth)) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (accept),
    .full       (fifo_full),
    .pop_ready  (req.d_ready),
    .empty      (fifo_empty),
    .push_data  (push_entry),
    .head_data  (head_entry)
  );

  // D fields are held at zero whenever nothing is queued, including reset.
  always_comb begin
    rsp         = '0;
    rsp.a_ready = a_ready;
    rsp.d_valid = !fifo_empty;
    if (!fifo_empty) begin
      rsp.d_opcode = head_entry.opcode;
      rsp.d_size   = head_entry.size;
      rsp.d_source = head_entry.source;
      rsp.d_data   = head_entry.data;
      rsp.d_error  = head_entry.error;
    end
  end

  assign tl.tl_o = rsp;

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Randomised and directed bench for tlul_mem_responder with a queue-based
// scoreboard fed by a spec-level memory model.
module tb_tlul_mem_responder;
  import tlul_pkg::*;

  localparam int Depth    = 16;
  localparam int RspDepth = 2;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  tlul_mem_responder_if tl_bus();

  tlul_mem_responder #(.Depth(Depth), .RspDepth(RspDepth)) dut (
    .clk (clk),
    .rst (rst),
    .tl  (tl_bus)
  );

  always #5 clk = ~clk;

  exp_t        scb[$];
  logic [31:0] mdl_mem [Depth];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          lat_mode = 0;
  bit          rand_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < Depth; i++) mdl_mem[i] = '0;
  endfunction

  // Response expected for one accepted request; memory side effects applied here.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [3:0] mask,
                                 input logic [31:0] data, input logic [7:0] src);
    exp_t e;
    int   w;
    bit   legal_op;
    legal_op = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
    w      = int'((addr / 4) % Depth);
    e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
    e.size = size;
    e.src  = src;
    e.data = '0;
    e.err  = !legal_op || (size > 2) || (addr >= 32'(Depth * 4));
    e.cyc  = 0;
    e.lat  = 0;
    if (!e.err) begin
      if (op == 3'd4) e.data = mdl_mem[w];
      else
        for (int b = 0; b < 4; b++)
          if (mask[b]) mdl_mem[w][8*b +: 8] = data[8*b +: 8];
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                               input logic [1:0] size, input logic [3:0] mask,
                               input logic [31:0] data, input logic [7:0] src);
    int waited = 0;
    bit done = 0;
    tl_bus.tl_i.a_valid   = 1'b1;
    tl_bus.tl_i.a_opcode  = op;
    tl_bus.tl_i.a_address = addr;
    tl_bus.tl_i.a_size    = size;
    tl_bus.tl_i.a_mask    = mask;
    tl_bus.tl_i.a_data    = data;
    tl_bus.tl_i.a_source  = src;
    while (!done) begin
      @(negedge clk);
      if (tl_bus.tl_o.a_ready) begin
        exp_t e;
        e     = model(op, addr, size, mask, data, src);
        e.cyc = cyc + 1;
        e.lat = lat_mode;
        scb.push_back(e);
        done = 1;
      end else begin
        waited++;
        if (waited > 100) begin
          checkOutput("a_ready_timeout", 64'd0, 64'd1);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    tl_bus.tl_i.a_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (scb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", 64'(scb.size()), 64'd0);
  endtask

  function automatic logic [63:0] pack_d(input tl_d2h_t d);
    return 64'({d.d_opcode, d.d_param, d.d_size, d.d_source, d.d_sink, d.d_user, d.d_data, d.d_error});
  endfunction

  // Monitor: pops the scoreboard on every D handshake and checks hold stability.
  initial begin
    bit      hold = 0;
    tl_d2h_t prev = '0;
    forever begin
      @(negedge clk);
      if (hold && tl_bus.tl_o.d_valid)
        checkOutput("d_stable", pack_d(tl_bus.tl_o), pack_d(prev));
      hold = tl_bus.tl_o.d_valid && !tl_bus.tl_i.d_ready;
      prev = tl_bus.tl_o;
      if (tl_bus.tl_o.d_valid && tl_bus.tl_i.d_ready) begin
        if (scb.size() == 0) begin
          checkOutput("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = scb.pop_front();
          checkOutput("rsp", pack_d(tl_bus.tl_o),
                      64'({e.op, 3'd0, e.size, e.src, 1'b0, 4'd0, e.data, e.err}));
          if (e.lat) checkOutput("latency", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] op_tab [8];
    op_tab = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd3, 3'd2, 3'd5, 3'd4};
    tl_bus.tl_i = '0;
    clear_model();

    #12;
    checkOutput("rst_a_ready", 64'(tl_bus.tl_o.a_ready), 64'd0);
    checkOutput("rst_d_valid", 64'(tl_bus.tl_o.d_valid), 64'd0);
    checkOutput("rst_tl_o", 64'(tl_bus.tl_o), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_a_ready", 64'(tl_bus.tl_o.a_ready), 64'd1);
    checkOutput("post_rst_d_valid", 64'(tl_bus.tl_o.d_valid), 64'd0);

    $display("[TB] directed write/read and error cases");
    tl_bus.tl_i.d_ready = 1'b1;
    applyStimulus(3'd0, 32'h8,  2'd2, 4'hF, 32'hDEADBEEF, 8'd5);
    applyStimulus(3'd4, 32'h8,  2'd2, 4'h0, 32'h0,        8'd6);
    applyStimulus(3'd1, 32'h8,  2'd2, 4'h2, 32'h0000AA00, 8'd7);
    applyStimulus(3'd4, 32'h8,  2'd2, 4'h0, 32'h0,        8'd8);
    applyStimulus(3'd4, 32'h40, 2'd2, 4'h0, 32'h0,        8'd9);
    applyStimulus(3'd3, 32'h8,  2'd2, 4'hF, 32'h11111111, 8'd10);
    applyStimulus(3'd0, 32'h8,  2'd3, 4'hF, 32'h12345678, 8'd11);
    applyStimulus(3'd0, 32'h8,  2'd2, 4'h0, 32'hFFFFFFFF, 8'd13);
    applyStimulus(3'd4, 32'h8,  2'd1, 4'h0, 32'h0,        8'd12);
    applyStimulus(3'd0, 32'h3C, 2'd2, 4'hF, 32'hCAFEF00D, 8'd14);
    applyStimulus(3'd4, 32'h3C, 2'd0, 4'h0, 32'h0,        8'd15);
    drain();

    $display("[TB] backpressure");
    tl_bus.tl_i.d_ready = 1'b0;
    applyStimulus(3'd4, 32'h8,  2'd2, 4'h0, 32'h0, 8'd20);
    applyStimulus(3'd4, 32'h3C, 2'd2, 4'h0, 32'h0, 8'd21);
    checkOutput("full_a_ready", 64'(tl_bus.tl_o.a_ready), 64'd0);
    tl_bus.tl_i.d_ready = 1'b1;
    @(posedge clk); #1;
    tl_bus.tl_i.d_ready = 1'b0;
    checkOutput("after_pop_a_ready", 64'(tl_bus.tl_o.a_ready), 64'd1);
    tl_bus.tl_i.d_ready = 1'b1;
    drain();

    $display("[TB] streaming");
    lat_mode = 1;
    for (int i = 0; i < 16; i++) applyStimulus(3'd4, 32'(i * 4), 2'd2, 4'h0, 32'h0, 8'(i));
    lat_mode = 0;
    drain();

    $display("[TB] random traffic");
    fork
      begin
        for (int i = 0; i < 300; i++)
          applyStimulus(op_tab[$urandom_range(7)], 32'($urandom_range(32'h4F)),
                        2'($urandom_range(3)), 4'($urandom), $urandom, 8'($urandom));
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          tl_bus.tl_i.d_ready = ($urandom_range(3) != 0);
        end
        tl_bus.tl_i.d_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset mid-operation");
    tl_bus.tl_i.d_ready = 1'b0;
    applyStimulus(3'd4, 32'h8, 2'd2, 4'h0, 32'h0, 8'd30);
    applyStimulus(3'd4, 32'h4, 2'd2, 4'h0, 32'h0, 8'd31);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_d_valid", 64'(tl_bus.tl_o.d_valid), 64'd0);
    checkOutput("midrst_a_ready", 64'(tl_bus.tl_o.a_ready), 64'd0);
    scb.delete();
    clear_model();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checkOutput("rel_a_ready", 64'(tl_bus.tl_o.a_ready), 64'd1);
    checkOutput("rel_d_valid", 64'(tl_bus.tl_o.d_valid), 64'd0);
    tl_bus.tl_i.d_ready = 1'b1;
    applyStimulus(3'd4, 32'h8, 2'd2, 4'h0, 32'h0, 8'd32);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
